// File: rtl/beehive_vr_pkg.sv
// rtl/beehive_vr_pkg.sv - shared widths and state encoding for the prepare log data writer
package beehive_vr_pkg;

    localparam int NOC_DATA_W  = 512;
    localparam int LOG_DEPTH_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        DONE
    } log_wr_state_e;

endpackage

// File: rtl/prep_log_data_writer_if.sv
// rtl/prep_log_data_writer_if.sv - control, payload stream and log memory handshakes of the log data writer
interface prep_log_data_writer_if #(
    parameter int NOC_DATA_W  = beehive_vr_pkg::NOC_DATA_W,
    parameter int LOG_DEPTH_W = beehive_vr_pkg::LOG_DEPTH_W
);
    logic                   ctrl_log_start_val;
    logic                   log_ctrl_start_rdy;
    logic [LOG_DEPTH_W:0]   ctrl_log_line_cnt;
    logic                   ctrl_log_drop;
    logic                   manage_log_data_val;
    logic                   log_manage_data_rdy;
    logic [NOC_DATA_W-1:0]  manage_log_data;
    logic                   manage_log_data_last;
    logic                   log_data_mem_wr_val;
    logic                   log_data_mem_wr_rdy;
    logic [NOC_DATA_W-1:0]  log_data_mem_wr_data;
    logic                   log_ctrl_datap_incr_wr_addr;
    logic                   log_ctrl_done_val;
    logic                   ctrl_log_done_rdy;
    logic                   log_ctrl_done_err;

    modport master (
        output ctrl_log_start_val, ctrl_log_line_cnt, ctrl_log_drop,
               manage_log_data_val, manage_log_data, manage_log_data_last,
               log_data_mem_wr_rdy, ctrl_log_done_rdy,
        input  log_ctrl_start_rdy, log_manage_data_rdy, log_data_mem_wr_val,
               log_data_mem_wr_data, log_ctrl_datap_incr_wr_addr,
               log_ctrl_done_val, log_ctrl_done_err
    );

    modport slave (
        input  ctrl_log_start_val, ctrl_log_line_cnt, ctrl_log_drop,
               manage_log_data_val, manage_log_data, manage_log_data_last,
               log_data_mem_wr_rdy, ctrl_log_done_rdy,
        output log_ctrl_start_rdy, log_manage_data_rdy, log_data_mem_wr_val,
               log_data_mem_wr_data, log_ctrl_datap_incr_wr_addr,
               log_ctrl_done_val, log_ctrl_done_err
    );

endinterface

// File: rtl/log_wr_pipe_stage.sv
// rtl/log_wr_pipe_stage.sv - one-entry registered stage before the log memory port (PREP_LOG_WR_PIPE_EN)
`ifdef PREP_LOG_WR_PIPE_EN
module log_wr_pipe_stage #(
    parameter int DATA_W = 512
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_val_i,
    output logic              in_rdy_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_val_o,
    input  logic              out_rdy_i,
    output logic [DATA_W-1:0] out_data_o
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              in_fire, out_fire;

    // Accepting while the entry drains keeps full throughput with a single register
    assign in_rdy_o   = ~full_q | out_rdy_i;
    assign in_fire    = in_val_i & in_rdy_o;
    assign out_fire   = full_q & out_rdy_i;
    assign out_val_o  = full_q;
    assign out_data_o = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_fire) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (out_fire) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
        data_q <= data_d;
    end

endmodule
`endif

// File: rtl/prep_log_data_writer.sv
// rtl/prep_log_data_writer.sv - streams prepare payload lines into log data memory; PREP_LOG_WR_PIPE_EN adds a registered write stage
module prep_log_data_writer
    import beehive_vr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    prep_log_data_writer_if.slave bus
);
    localparam logic [LOG_DEPTH_W:0] REM_ONE = {{LOG_DEPTH_W{1'b0}}, 1'b1};

    log_wr_state_e        state_q, state_d;
    logic [LOG_DEPTH_W:0] rem_q, rem_d;
    logic                 err_q, err_d;

    logic start_rdy, data_rdy, done_pend, push;
    logic wr_path_rdy, stage_empty, wr_val;

`ifdef PREP_LOG_WR_PIPE_EN
    logic                  st_full;
    logic [NOC_DATA_W-1:0] st_data;

    log_wr_pipe_stage #(.DATA_W(NOC_DATA_W)) u_pipe (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_val_i   (push & ~rst),
        .in_rdy_o   (wr_path_rdy),
        .in_data_i  (bus.manage_log_data),
        .out_val_o  (st_full),
        .out_rdy_i  (bus.log_data_mem_wr_rdy),
        .out_data_o (st_data)
    );

    assign stage_empty              = ~st_full;
    assign wr_val                   = st_full & ~rst;
    assign bus.log_data_mem_wr_data = st_data;
`else
    assign wr_path_rdy              = bus.log_data_mem_wr_rdy;
    assign stage_empty              = 1'b1;
    assign wr_val                   = (state_q == WRITE) & bus.manage_log_data_val & ~rst;
    assign bus.log_data_mem_wr_data = bus.manage_log_data;
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        err_d     = err_q;
        start_rdy = 1'b0;
        data_rdy  = 1'b0;
        done_pend = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                start_rdy = 1'b1;
                if (bus.ctrl_log_start_val) begin
                    rem_d = bus.ctrl_log_line_cnt;
                    err_d = 1'b0;
                    if (bus.ctrl_log_drop)                state_d = DRAIN;
                    else if (bus.ctrl_log_line_cnt == '0) state_d = DONE;
                    else                                  state_d = WRITE;
                end
            end
            WRITE: begin
                data_rdy = wr_path_rdy;
                if (bus.manage_log_data_val && wr_path_rdy) begin
                    push = 1'b1;
                    if (rem_q != '0) rem_d = rem_q - REM_ONE;
                    if (bus.manage_log_data_last) begin
                        if (rem_q != REM_ONE) err_d = 1'b1;
                        state_d = DONE;
                    end else if (rem_q == REM_ONE) begin
                        // Message longer than announced: flag it and discard the tail
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                data_rdy = 1'b1;
                if (bus.manage_log_data_val && bus.manage_log_data_last) state_d = DONE;
            end
            DONE: begin
                // Completion is held back until every registered line has reached memory
                done_pend = stage_empty;
                if (stage_empty && bus.ctrl_log_done_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.log_ctrl_start_rdy          = start_rdy;
    assign bus.log_manage_data_rdy         = data_rdy & ~rst;
    assign bus.log_data_mem_wr_val         = wr_val;
    assign bus.log_ctrl_datap_incr_wr_addr = wr_val & bus.log_data_mem_wr_rdy;
    assign bus.log_ctrl_done_val           = done_pend & ~rst;
    assign bus.log_ctrl_done_err           = done_pend & err_q & ~rst;

endmodule

// File: tb/tb_prep_log_data_writer.sv
// tb/tb_prep_log_data_writer.sv - directed self-checking bench for prep_log_data_writer
module tb_prep_log_data_writer;
    import beehive_vr_pkg::*;

`ifdef PREP_LOG_WR_PIPE_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prep_log_data_writer_if bus ();

    prep_log_data_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int incr_cnt = 0, wrval_cnt = 0, cons_cnt = 0;
    int first_cons = -1, first_incr = -1, last_incr = -1, done_cyc = -1;
    int stall_cnt = 0, mirror_bad = 0;
    logic toggle_en = 1'b0;
    logic [NOC_DATA_W-1:0] wq[$];

    always @(negedge clk) begin
        #2;
        if (bus.log_ctrl_datap_incr_wr_addr === 1'b1) begin
            incr_cnt++;
            last_incr = cyc;
            if (first_incr < 0) first_incr = cyc;
        end
        if (bus.log_data_mem_wr_val === 1'b1) begin
            wrval_cnt++;
            if (bus.log_data_mem_wr_rdy) wq.push_back(bus.log_data_mem_wr_data);
        end
        if (bus.manage_log_data_val && bus.log_manage_data_rdy === 1'b1) begin
            cons_cnt++;
            if (first_cons < 0) first_cons = cyc;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (toggle_en) bus.log_data_mem_wr_rdy = ~bus.log_data_mem_wr_rdy;
    end

    function automatic logic [NOC_DATA_W-1:0] mk(input int v);
        return {16{v}};
    endfunction

    task automatic do_start(input int cnt, input logic drop);
        bit ok = 0;
        bus.ctrl_log_start_val = 1'b1;
        bus.ctrl_log_line_cnt  = (LOG_DEPTH_W+1)'(cnt);
        bus.ctrl_log_drop      = drop;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = bus.log_ctrl_start_rdy;
            @(posedge clk);
            @(negedge clk);
        end
        bus.ctrl_log_start_val = 1'b0;
        bus.ctrl_log_drop      = 1'b0;
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL start_accept: start_rdy never seen, required 1");
        end
    endtask

    task automatic send_msg(input int n, input int last_idx, input int base);
        bit ok;
        bit r;
        for (int i = 0; i < n; i++) begin
            bus.manage_log_data_val  = 1'b1;
            bus.manage_log_data      = mk(base + i);
            bus.manage_log_data_last = (i == last_idx);
            ok = 0;
            for (int k = 0; k < 50 && !ok; k++) begin
                #1;
                r = bus.log_manage_data_rdy;
                if (!r) stall_cnt++;
                if (toggle_en && (r !== bus.log_data_mem_wr_rdy)) mirror_bad++;
                @(posedge clk);
                ok = r;
                @(negedge clk);
            end
            vec++;
            if (!ok) begin
                errs++;
                $display("FAIL line_accept: line %0d not taken, data_rdy stuck at 0, required 1", i);
            end
        end
        bus.manage_log_data_val  = 1'b0;
        bus.manage_log_data_last = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input string name);
        bit ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (bus.log_ctrl_done_val === 1'b1) begin
                ok = 1;
                done_cyc = cyc;
                vec++;
                if (bus.log_ctrl_done_err !== exp_err) begin
                    errs++;
                    $display("FAIL %s_done_err: got %b required %b", name, bus.log_ctrl_done_err, exp_err);
                end
                bus.ctrl_log_done_rdy = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.ctrl_log_done_rdy = 1'b0;
                #1;
                vec++;
                if (bus.log_ctrl_start_rdy !== 1'b1) begin
                    errs++;
                    $display("FAIL %s_start_rdy_after_done: got %b required 1", name, bus.log_ctrl_start_rdy);
                end
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL %s_done_timeout: done_val stayed 0, required 1", name);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic check_writes(input string name, input int base, input int n);
        logic [NOC_DATA_W-1:0] d;
        check_int({name, "_write_count"}, wq.size(), n);
        for (int i = 0; i < n && wq.size() > 0; i++) begin
            d = wq.pop_front();
            vec++;
            if (d !== mk(base + i)) begin
                errs++;
                $display("FAIL %s_write_data[%0d]: got %h required %h", name, i, d[31:0], base + i);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ctrl_log_start_val   = 1'b0;
        bus.ctrl_log_line_cnt    = '0;
        bus.ctrl_log_drop        = 1'b0;
        bus.manage_log_data_val  = 1'b0;
        bus.manage_log_data      = '0;
        bus.manage_log_data_last = 1'b0;
        bus.log_data_mem_wr_rdy  = 1'b1;
        bus.ctrl_log_done_rdy    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_int("reset_start_rdy", int'(bus.log_ctrl_start_rdy), 1);
        check_int("reset_data_rdy", int'(bus.log_manage_data_rdy), 0);
        check_int("reset_wr_val", int'(bus.log_data_mem_wr_val), 0);
        check_int("reset_incr", int'(bus.log_ctrl_datap_incr_wr_addr), 0);
        check_int("reset_done_val", int'(bus.log_ctrl_done_val), 0);
        check_int("reset_done_err", int'(bus.log_ctrl_done_err), 0);
        @(negedge clk);
    endtask

    task automatic test_basic();
        int i0 = incr_cnt;
        wq.delete();
        first_cons = -1;
        first_incr = -1;
        do_start(3, 1'b0);
        send_msg(3, 2, 32'hA0);
        wait_done(1'b0, "basic");
        check_int("basic_incr", incr_cnt - i0, 3);
        check_writes("basic", 32'hA0, 3);
        check_int("basic_latency", first_incr - first_cons, EXP_LAT);
        check_int("basic_done_after_incr", int'(done_cyc > last_incr), 1);
    endtask

    task automatic test_backpressure();
        int i0 = incr_cnt;
        wq.delete();
        mirror_bad = 0;
        toggle_en  = 1'b1;
        do_start(3, 1'b0);
        send_msg(3, 2, 32'hB0);
        toggle_en = 1'b0;
        bus.log_data_mem_wr_rdy = 1'b1;
        wait_done(1'b0, "bp");
        check_int("bp_incr", incr_cnt - i0, 3);
        check_writes("bp", 32'hB0, 3);
`ifndef PREP_LOG_WR_PIPE_EN
        check_int("bp_data_rdy_mirror", mirror_bad, 0);
`endif
    endtask

    task automatic test_drop();
        int i0 = incr_cnt, w0 = wrval_cnt, c0 = cons_cnt;
        stall_cnt = 0;
        do_start(4, 1'b1);
        send_msg(4, 3, 32'hC0);
        wait_done(1'b0, "drop");
        check_int("drop_incr", incr_cnt - i0, 0);
        check_int("drop_wr_val", wrval_cnt - w0, 0);
        check_int("drop_consumed", cons_cnt - c0, 4);
        check_int("drop_stalls", stall_cnt, 0);
    endtask

    task automatic test_overlong();
        int i0 = incr_cnt, c0 = cons_cnt;
        wq.delete();
        do_start(2, 1'b0);
        send_msg(4, 3, 32'hD0);
        wait_done(1'b1, "long");
        check_int("long_incr", incr_cnt - i0, 2);
        check_int("long_consumed", cons_cnt - c0, 4);
        check_writes("long", 32'hD0, 2);
    endtask

    task automatic test_short();
        int i0 = incr_cnt;
        wq.delete();
        do_start(3, 1'b0);
        send_msg(2, 1, 32'hE0);
        wait_done(1'b1, "short");
        check_int("short_incr", incr_cnt - i0, 2);
        check_writes("short", 32'hE0, 2);
    endtask

    task automatic test_zero();
        int c0 = cons_cnt;
        do_start(0, 1'b0);
        #1;
        check_int("zero_done_1cyc", int'(bus.log_ctrl_done_val), 1);
        wait_done(1'b0, "zero");
        check_int("zero_consumed", cons_cnt - c0, 0);
    endtask

    task automatic test_reset_mid_write();
        int i0 = incr_cnt, w0;
        do_start(3, 1'b0);
        send_msg(1, -1, 32'hF0);
        w0 = wrval_cnt;
        bus.manage_log_data_val = 1'b1;
        bus.manage_log_data     = mk(32'hF1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.manage_log_data_val = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_int("rstmid_incr", incr_cnt - i0, 1);
        check_int("rstmid_wr_val_after", wrval_cnt - w0, 0);
        check_int("rstmid_idle_start_rdy", int'(bus.log_ctrl_start_rdy), 1);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_overlong();
        test_short();
        test_zero();
        test_reset_mid_write();
        test_basic();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
